wave_capture: RTL

Sample-capture front end for the waveform display path. Watches the audio sample stream, arms on a positive-going zero crossing, and writes one screen's worth of samples into the write port of the dual-read sample RAM. The RAM is split into two halves, and the block flips which half the display reads once the display reports idle. It is the writer/initiator that drives the RAM's write port; the display consumes the other half through a read port.

---
 rtl/wave_capture.sv | 134 +++++++++++++
 1 files changed

// File: rtl/wave_capture.sv
// wave_capture
//
// Capture front end for the waveform display. Watches the 16-bit signed
// audio stream, arms on a negative-to-non-negative zero crossing, and writes
// one half of the sample RAM (2^(DEPTH-1) samples) through the RAM write
// port. Once a half is full it waits for the display to go idle, then flips
// read_index so the display picks up the freshly written half.
//
// Ports:
//   clk               - system clock, rising edge
//   reset             - synchronous active-high reset
//   new_sample_ready  - one-cycle strobe, new_sample_in valid
//   new_sample_in     - signed 16-bit audio sample
//   wave_display_idle - display is not scanning the RAM
//   write_address     - RAM write address {~read_index, offset}
//   write_enable      - RAM write strobe (one cycle per stored sample)
//   write_sample      - RAM write data, unsigned offset-binary
//   read_index        - RAM half the display reads
//   armed             - high while waiting for a trigger
module wave_capture #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             new_sample_ready,
    input  logic [15:0]      new_sample_in,
    input  logic             wave_display_idle,
    output logic [DEPTH-1:0] write_address,
    output logic             write_enable,
    output logic [WIDTH-1:0] write_sample,
    output logic             read_index,
    output logic             armed
);

    typedef enum logic [1:0] {
        ST_ARMED  = 2'd0,
        ST_ACTIVE = 2'd1,
        ST_WAIT   = 2'd2
    } state_t;

    localparam logic [DEPTH-2:0] LAST_OFFSET = {(DEPTH-1){1'b1}};

    state_t           state, state_next;
    logic [DEPTH-2:0] offset, offset_next;
    logic [15:0]      prev_sample, prev_sample_next;
    logic [DEPTH-1:0] write_address_next;
    logic             write_enable_next;
    logic [WIDTH-1:0] write_sample_next;
    logic             read_index_next;
    logic             armed_next;
    logic             crossing;
    logic [WIDTH-1:0] converted;

    // Flipping the sign bit turns two's complement into offset-binary, so
    // the most negative sample lands at 0 and zero lands mid-scale.
    assign converted = {~new_sample_in[15], new_sample_in[14:16-WIDTH]};

    // Zero is treated as non-negative, so -x followed by 0 triggers.
    assign crossing = new_sample_ready & prev_sample[15] & ~new_sample_in[15];

    // State and every output are registered; reset wins over all inputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= ST_ARMED;
            offset        <= '0;
            prev_sample   <= '0;
            write_address <= '0;
            write_enable  <= 1'b0;
            write_sample  <= '0;
            read_index    <= 1'b0;
            armed         <= 1'b1;
        end else begin
            state         <= state_next;
            offset        <= offset_next;
            prev_sample   <= prev_sample_next;
            write_address <= write_address_next;
            write_enable  <= write_enable_next;
            write_sample  <= write_sample_next;
            read_index    <= read_index_next;
            armed         <= armed_next;
        end
    end

    // Next-state and next-output logic. Address and data hold between
    // writes; only write_enable returns to zero by default.
    always_comb begin
        state_next         = state;
        offset_next        = offset;
        prev_sample_next   = new_sample_ready ? new_sample_in : prev_sample;
        write_address_next = write_address;
        write_enable_next  = 1'b0;
        write_sample_next  = write_sample;
        read_index_next    = read_index;

        case (state)
            ST_ARMED: begin
                if (crossing) begin
                    write_enable_next  = 1'b1;
                    write_address_next = {~read_index, {(DEPTH-1){1'b0}}};
                    write_sample_next  = converted;
                    offset_next        = {{(DEPTH-2){1'b0}}, 1'b1};
                    state_next         = ST_ACTIVE;
                end
            end
            ST_ACTIVE: begin
                if (new_sample_ready) begin
                    write_enable_next  = 1'b1;
                    write_address_next = {~read_index, offset};
                    write_sample_next  = converted;
                    if (offset == LAST_OFFSET) begin
                        offset_next = '0;
                        state_next  = ST_WAIT;
                    end else begin
                        offset_next = offset + 1'b1;
                    end
                end
            end
            ST_WAIT: begin
                // The writer is idle here, so flipping the half is safe.
                if (wave_display_idle) begin
                    read_index_next = ~read_index;
                    state_next      = ST_ARMED;
                end
            end
            default: begin
                state_next = ST_ARMED;
            end
        endcase

        armed_next = (state_next == ST_ARMED);
    end

endmodule
